regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back controller for the RV32I 32×32 register file. It sits between the two write-back sources, the ALU result path and the load/store unit (LSU) load-return path, and the register file's single write port. After reset it sequences a zero-fill of all registers, because the register file itself has no reset. It then arbitrates the write port between the two requesters with valid/ready handshakes, LSU priority and bounded ALU starvation.

## Interface
- NUM_REGS, 32, number of architectural registers swept at init
- IDX_W, 5, register index width
- DATA_W, 32, write data width
- STARVE_LIMIT, 4, consecutive ALU losses before the ALU is granted priority (1..15)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- init_done  out  1  high once the zero-fill sweep has completed
- alu_valid  in  1  ALU write-back request
- alu_ready  out  1  ALU request accepted this cycle when high together with alu_valid
- alu_rd  in  IDX_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- lsu_valid  in  1  LSU load-return write-back request
- lsu_ready  out  1  LSU request accepted this cycle when high together with lsu_valid
- lsu_rd  in  IDX_W  LSU destination register
- lsu_data  in  DATA_W  load data
- rf_write  out  1  register file write enable, registered
- rf_write_reg  out  IDX_W  register file write index, registered
- rf_write_data  out  DATA_W  register file write data, registered

## Operation
- States: INIT, RUN. Reset forces INIT with sweep index 0.
- INIT:
  - rf_write=1, rf_write_reg=sweep index, rf_write_data=0 each cycle.
  - Index increments 0..NUM_REGS-1. After index NUM_REGS-1 is issued: move to RUN, init_done=1.
  - Both ready outputs are 0 throughout INIT.
- RUN, ready generation (combinational):
  - alu_ready = ~lsu_valid | alu_pri
  - lsu_ready = ~alu_valid | ~alu_pri
  - Each ready depends only on the other requester's valid and on internal state, never on its own valid.
- Transfer: valid&ready on a requester. At most one transfer per cycle.
- Requester obligation: hold valid, rd and data stable until its transfer.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when alu_valid&lsu_valid and the LSU transfers.
  - alu_pri = (count == STARVE_LIMIT).
  - Clears to 0 on an ALU transfer.
- Write issue: a transfer with rd≠0 drives rf_write=1, rf_write_reg=rd, rf_write_data=data on the next cycle. Otherwise rf_write=0 in RUN.
- rd==0: the handshake completes normally, but no write is issued, so x0 stays zero.
- rf_write_reg and rf_write_data hold their last values when rf_write=0.

## Timing
- Reset values: init_done=0, alu_ready=0, lsu_ready=0, rf_write=0, rf_write_reg=0, rf_write_data=0, state INIT, starvation count 0.
- First cycle after reset release: rf_write=1, rf_write_reg=0.
- Sweep occupies exactly NUM_REGS cycles. init_done rises the cycle after the last sweep write is presented; the ready outputs become live in that same cycle.
- Write-back latency:
  - Transfer in cycle N → rf_write in cycle N+1 → new value readable from the register file in cycle N+2.
  - No bypass is provided here.
- Throughput: one write per cycle, sustained.
- Simultaneous valids with alu_pri=0 → LSU wins. With alu_pri=1 → ALU wins and the counter clears.
- Reset in any state, including mid-sweep and with an issue pending: the pending write is discarded (rf_write=0 next cycle) and the sweep restarts from index 0.

## Structure
- Shared package rv32i_rf_pkg: IDX_W, DATA_W, NUM_REGS constants; state enum {INIT, RUN}. The register file and decode stages also use this package.
- One sub-module is natural: wb_starve_ctr, the saturating counter with increment/clear inputs and a limit-reached output.
- Everything else is flat in regfile_wb_arbiter.

## Test plan
- Reset, no requests:
  - 32 consecutive cycles with rf_write=1, indices 0..31, data 0.
  - init_done=1 on cycle 33; no rf_write afterwards.
- After init, alu_valid with rd=5, data=0xDEADBEEF:
  - alu_ready=1 in the same cycle.
  - Next cycle: rf_write=1, reg 5, data 0xDEADBEEF.
- Both valid:
  - LSU rd=7, data=0x11 for 1 cycle; ALU rd=8, data=0x22.
  - LSU is written first, ALU one cycle later; writes are back-to-back.
- STARVE_LIMIT=4, alu_valid held while LSU presents 6 back-to-back requests:
  - 4 LSU writes, then the ALU write, then the remaining 2 LSU writes.
  - Counter is 0 after the ALU transfer.
- LSU request with rd=0, data=0xFFFF_FFFF:
  - lsu_ready=1 and the handshake completes.
  - rf_write stays 0 the next cycle.
- Reset asserted at sweep index 17:
  - rf_write=0 on the cycle after reset.
  - After release the sweep restarts at index 0, and init_done stays 0 for 32 cycles.

Source files
------------

// File: rtl/rv32i_rf_pkg.sv
// Shared RV32I register-file definitions used by write-back, register file and decode.
// Holds the architectural sizes and the write-back controller state encoding.
package rv32i_rf_pkg;

  localparam int IDX_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating ALU starvation counter: counts LSU wins over a waiting ALU,
// clears when the ALU finally transfers, flags when the limit is reached.
module wb_starve_ctr #(
  parameter int LIMIT = 4,
  parameter int CNT_W = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  logic [CNT_W-1:0] count_r;

  // Counter register: clear has priority over increment, increment saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= CNT_W'(0);
    end else if (clr) begin
      count_r <= CNT_W'(0);
    end else if (inc && (count_r != CNT_W'(LIMIT))) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign limit_hit = (count_r == CNT_W'(LIMIT));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the RV32I register file: zero-fills all registers after
// reset, then arbitrates the single write port between the ALU and LSU write-back paths.
module regfile_wb_arbiter
  import rv32i_rf_pkg::*;
#(
  parameter int NUM_REGS     = rv32i_rf_pkg::NUM_REGS,
  parameter int IDX_W        = rv32i_rf_pkg::IDX_W,
  parameter int DATA_W       = rv32i_rf_pkg::DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [IDX_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [IDX_W-1:0]  lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              rf_write,
  output logic [IDX_W-1:0]  rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data
);

  wb_state_e         state_r, state_s;
  logic [IDX_W-1:0]  sweep_idx_r, sweep_idx_s;
  logic              init_done_r;
  logic              rf_write_r, wr_en_s;
  logic [IDX_W-1:0]  rf_write_reg_r, wr_reg_s;
  logic [DATA_W-1:0] rf_write_data_r, wr_data_s;

  logic alu_pri_s, alu_ready_s, lsu_ready_s;
  logic alu_xfer_s, lsu_xfer_s, starve_inc_s;

  wb_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (4)
  ) u_starve_ctr (
    .clock     (clock),
    .reset     (reset),
    .inc       (starve_inc_s),
    .clr       (alu_xfer_s),
    .limit_hit (alu_pri_s)
  );

  // Ready generation: each side's ready looks only at the other side's valid, so
  // neither requester can form a combinational loop through its own valid.
  always_comb begin
    alu_ready_s = 1'b0;
    lsu_ready_s = 1'b0;
    if (init_done_r) begin
      alu_ready_s = ~lsu_valid | alu_pri_s;
      lsu_ready_s = ~alu_valid | ~alu_pri_s;
    end else begin
      alu_ready_s = 1'b0;
      lsu_ready_s = 1'b0;
    end
  end

  assign alu_xfer_s   = alu_valid & alu_ready_s;
  assign lsu_xfer_s   = lsu_valid & lsu_ready_s & ~alu_xfer_s;
  assign starve_inc_s = alu_valid & lsu_valid & lsu_xfer_s;

  // Next-state and write-issue logic; writes to x0 complete the handshake but issue nothing.
  always_comb begin
    state_s     = state_r;
    sweep_idx_s = sweep_idx_r;
    wr_en_s     = 1'b0;
    wr_reg_s    = rf_write_reg_r;
    wr_data_s   = rf_write_data_r;
    case (state_r)
      INIT: begin
        wr_en_s   = 1'b1;
        wr_reg_s  = sweep_idx_r;
        wr_data_s = DATA_W'(0);
        if (sweep_idx_r == IDX_W'(NUM_REGS - 1)) begin
          state_s     = RUN;
          sweep_idx_s = IDX_W'(0);
        end else begin
          sweep_idx_s = sweep_idx_r + IDX_W'(1);
        end
      end
      RUN: begin
        if (alu_xfer_s && (|alu_rd)) begin
          wr_en_s   = 1'b1;
          wr_reg_s  = alu_rd;
          wr_data_s = alu_data;
        end else if (lsu_xfer_s && (|lsu_rd)) begin
          wr_en_s   = 1'b1;
          wr_reg_s  = lsu_rd;
          wr_data_s = lsu_data;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: begin
        state_s     = INIT;
        sweep_idx_s = IDX_W'(0);
      end
    endcase
  end

  // State and registered write-port outputs; init_done trails the last sweep write by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= INIT;
      sweep_idx_r     <= IDX_W'(0);
      init_done_r     <= 1'b0;
      rf_write_r      <= 1'b0;
      rf_write_reg_r  <= IDX_W'(0);
      rf_write_data_r <= DATA_W'(0);
    end else begin
      state_r         <= state_s;
      sweep_idx_r     <= sweep_idx_s;
      init_done_r     <= (state_r == RUN);
      rf_write_r      <= wr_en_s;
      rf_write_reg_r  <= wr_reg_s;
      rf_write_data_r <= wr_data_s;
    end
  end

  assign init_done     = init_done_r;
  assign alu_ready     = alu_ready_s;
  assign lsu_ready     = lsu_ready_s;
  assign rf_write      = rf_write_r;
  assign rf_write_reg  = rf_write_reg_r;
  assign rf_write_data = rf_write_data_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected register-file
// writes into a queue, a negedge monitor pops and compares every rf_write.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        init_done;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  regfile_wb_arbiter #(
    .NUM_REGS     (32),
    .IDX_W        (5),
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .init_done     (init_done),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_data      (lsu_data),
    .rf_write      (rf_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  // Monitor: every presented write must match the oldest expected write.
  always @(negedge clock) begin
    logic [36:0] e;
    if (rf_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got reg=%0d data=%h required no write",
                 rf_write_reg, rf_write_data);
      end else begin
        e = exp_q.pop_front();
        chk("rf_write", {27'd0, rf_write_reg, rf_write_data}, {27'd0, e});
      end
    end
  end

  // Releases reset and checks the 32-cycle sweep and the init_done/ready timing.
  task automatic sweep_and_check();
    for (int i = 0; i < 32; i++) push_wr(5'(i), 32'h0);
    reset = 1'b0;
    repeat (32) tick();
    chk("init_done_during_last_sweep", {63'd0, init_done}, 64'd0);
    chk("alu_ready_during_last_sweep", {63'd0, alu_ready}, 64'd0);
    tick();
    chk("init_done_after_sweep", {63'd0, init_done}, 64'd1);
    chk("alu_ready_idle", {63'd0, alu_ready}, 64'd1);
    chk("lsu_ready_idle", {63'd0, lsu_ready}, 64'd1);
  endtask

  initial begin
    logic exp_alu [7];
    int k;
    exp_alu = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'h0;
    repeat (3) tick();
    chk("reset_rf_write", {63'd0, rf_write}, 64'd0);
    chk("reset_rf_write_reg", {59'd0, rf_write_reg}, 64'd0);
    chk("reset_init_done", {63'd0, init_done}, 64'd0);
    chk("reset_readies", {62'd0, alu_ready, lsu_ready}, 64'd0);
    sweep_and_check();
    repeat (3) tick();

    // Single ALU write.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    @(negedge clock);
    chk("alu_only_ready", {63'd0, alu_ready}, 64'd1);
    push_wr(5'd5, 32'hDEADBEEF);
    tick();
    alu_valid = 1'b0;
    repeat (2) tick();

    // Simultaneous requests: LSU first, ALU the next cycle.
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h22;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h11;
    @(negedge clock);
    chk("both_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    chk("both_alu_ready", {63'd0, alu_ready}, 64'd0);
    push_wr(5'd7, 32'h11);
    tick();
    lsu_valid = 1'b0;
    @(negedge clock);
    chk("both_alu_second", {63'd0, alu_ready}, 64'd1);
    push_wr(5'd8, 32'h22);
    tick();
    alu_valid = 1'b0;
    repeat (2) tick();

    // Starvation: ALU held, 6 back-to-back LSU requests.
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hA;
    k = 0;
    for (int c = 0; c < 7; c++) begin
      lsu_valid = (k < 6);
      lsu_rd    = 5'(10 + k);
      lsu_data  = 32'h100 + 32'(k);
      @(negedge clock);
      chk("starve_alu_ready", {63'd0, alu_ready}, {63'd0, exp_alu[c]});
      chk("starve_lsu_ready", {63'd0, lsu_ready}, {63'd0, ~exp_alu[c]});
      if (exp_alu[c]) begin
        push_wr(5'd9, 32'hA);
      end else begin
        push_wr(5'(10 + k), 32'h100 + 32'(k));
        k++;
      end
      tick();
      if (exp_alu[c]) alu_valid = 1'b0;
    end
    lsu_valid = 1'b0;
    repeat (2) tick();

    // Counter must be clear again: LSU wins the next tie.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    @(negedge clock);
    chk("post_starve_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    chk("post_starve_alu_ready", {63'd0, alu_ready}, 64'd0);
    push_wr(5'd4, 32'h44);
    tick();
    lsu_valid = 1'b0;
    @(negedge clock);
    push_wr(5'd3, 32'h33);
    tick();
    alu_valid = 1'b0;

    // Write to x0: handshake completes, no write, outputs hold.
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
    @(negedge clock);
    chk("x0_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    tick();
    lsu_valid = 1'b0;
    @(negedge clock);
    chk("x0_no_write", {63'd0, rf_write}, 64'd0);
    chk("hold_reg_data", {27'd0, rf_write_reg, rf_write_data}, {27'd0, 5'd3, 32'h33});
    tick();

    // Reset in mid-sweep at index 17.
    reset = 1'b1;
    tick();
    for (int i = 0; i < 18; i++) push_wr(5'(i), 32'h0);
    reset = 1'b0;
    repeat (18) tick();
    chk("mid_sweep_reg17", {59'd0, rf_write_reg}, 64'd17);
    reset = 1'b1;
    tick();
    chk("reset_discards_write", {63'd0, rf_write}, 64'd0);
    chk("reset_clears_done", {63'd0, init_done}, 64'd0);
    sweep_and_check();
    repeat (3) tick();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
